// File: rtl/matvec_pkg.sv
// Shared types and helpers for the sequential complex matrix-vector multiplier.
//
// Contents:
//   cplx_t     - complex operand {re, im}; fields are wide enough for any
//                supported word width and carry sign-extended values.
//   sat_t      - scaled result plus an overflow flag.
//   state_e    - FSM state encoding (IDLE, RUN, DONE).
//   acc_width  - accumulator width for a given word width and qubit count.
//   vec_dim    - vector dimension D = 2**qb.
//   sat_round  - arithmetic shift by frac, optional round-half-up, saturate.
//
// Build option: define MATVEC_ROUND_EN to add 2**(frac-1) before the shift
// (round half up toward +inf); otherwise the shift truncates (floor).
package matvec_pkg;

  localparam int CPLX_W = 32;  // container width of cplx_t fields
  localparam int WIDE_W = 64;  // working width for scaling

  typedef struct packed {
    logic signed [CPLX_W-1:0] re;
    logic signed [CPLX_W-1:0] im;
  } cplx_t;

  typedef struct packed {
    logic signed [CPLX_W-1:0] val;
    logic                     ovf;
  } sat_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Products are 2n bits; summing 2**qb complex terms (each a difference of
  // two products) needs qb+1 more bits so no intermediate value can overflow.
  function automatic int acc_width(input int n, input int qb);
    return 2 * n + qb + 1;
  endfunction

  function automatic int vec_dim(input int qb);
    return 1 << qb;
  endfunction

  function automatic sat_t sat_round(input logic signed [WIDE_W-1:0] acc,
                                     input int n, input int frac);
    logic signed [WIDE_W-1:0] t;
    logic signed [WIDE_W-1:0] hi;
    logic signed [WIDE_W-1:0] lo;
    sat_t                     r;
    t = acc;
`ifdef MATVEC_ROUND_EN
    t = t + (WIDE_W'(1) << (frac - 1));
`endif
    t  = t >>> frac;
    hi = (WIDE_W'(1) << (n - 1)) - WIDE_W'(1);
    lo = -(WIDE_W'(1) << (n - 1));
    r.val = t[CPLX_W-1:0];
    r.ovf = 1'b0;
    if (t > hi) begin
      r.val = hi[CPLX_W-1:0];
      r.ovf = 1'b1;
    end else if (t < lo) begin
      r.val = lo[CPLX_W-1:0];
      r.ovf = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/matvec_seq_if.sv
// Handshake and data bundle of matvec_seq.
//
// Signals:
//   start     - launch request (sampled by the multiplier only when idle)
//   matrix    - D x D complex matrix, row-major, element k: re at 2k, im at 2k+1
//   i_vector  - input vector, interleaved re/im
//   busy      - run in progress (RUN or DONE)
//   done      - one-cycle completion pulse
//   o_vector  - registered result, interleaved re/im
//   ovr       - sticky saturation flag of the current/last run
//
// Modports: master drives the request side, slave is the multiplier.
interface matvec_seq_if
  import matvec_pkg::*;
#(
  parameter int N  = 16,
  parameter int QB = 2
);

  localparam int D = vec_dim(QB);

  logic         start;
  logic [N-1:0] matrix   [0:2*D*D-1];
  logic [N-1:0] i_vector [0:2*D-1];
  logic         busy;
  logic         done;
  logic [N-1:0] o_vector [0:2*D-1];
  logic         ovr;

  modport master (
    output start, matrix, i_vector,
    input  busy, done, o_vector, ovr
  );

  modport slave (
    input  start, matrix, i_vector,
    output busy, done, o_vector, ovr
  );

endinterface

// File: rtl/matvec_seq_cmac_lane.sv
// cmac_lane: one complex multiply-accumulate lane.
//
// Ports:
//   clk, rst_n     - clock, asynchronous active-low reset
//   clr            - zero the accumulator on this edge (wins over en)
//   en             - accumulate the current product on this edge
//   m, v           - complex operands (sign-extended N-bit values)
//   sum_re, sum_im - accumulator plus the current product (combinational),
//                    so the caller can capture a row total on its last
//                    column while the same edge clears the accumulator.
module cmac_lane
  import matvec_pkg::*;
#(
  parameter  int N     = 16,
  parameter  int QB    = 2,
  localparam int ACC_W = acc_width(N, QB)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    en,
  input  cplx_t                   m,
  input  cplx_t                   v,
  output logic signed [ACC_W-1:0] sum_re,
  output logic signed [ACC_W-1:0] sum_im
);

  logic signed [N-1:0]     mr, mi, vr, vi;
  logic signed [2*N-1:0]   p_rr, p_ii, p_ri, p_ir;
  logic signed [ACC_W-1:0] acc_re, acc_im;
  logic                    unused_hi;

  assign mr = m.re[N-1:0];
  assign mi = m.im[N-1:0];
  assign vr = v.re[N-1:0];
  assign vi = v.im[N-1:0];

  // Upper container bits are sign copies and carry no information.
  assign unused_hi = ^{m.re[CPLX_W-1:N], m.im[CPLX_W-1:N],
                       v.re[CPLX_W-1:N], v.im[CPLX_W-1:N]};

  assign p_rr = mr * vr;
  assign p_ii = mi * vi;
  assign p_ri = mr * vi;
  assign p_ir = mi * vr;

  assign sum_re = acc_re + ACC_W'(p_rr) - ACC_W'(p_ii);
  assign sum_im = acc_im + ACC_W'(p_ri) + ACC_W'(p_ir);

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_re <= '0;
      acc_im <= '0;
    end else if (clr) begin
      acc_re <= '0;
      acc_im <= '0;
    end else if (en) begin
      acc_re <= sum_re;
      acc_im <= sum_im;
    end
  end

endmodule

// File: rtl/matvec_seq.sv
// matvec_seq: sequential complex matrix-vector multiplier, o = M * v.
// M is D x D, v has D elements, D = 2**QB. LANES rows are computed in
// parallel, one column per cycle, so a run takes D*D/LANES RUN cycles
// followed by one DONE cycle.
//
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset (aborts a run)
//   bus        - matvec_seq_if.slave: start/matrix/i_vector in,
//                busy/done/o_vector/ovr out
//
// Parameters: N word width, FRAC fractional bits, QB qubit count,
// LANES parallel rows (power of two dividing D).
//
// Build option: MATVEC_ROUND_EN selects round-half-up before saturation;
// without it results are truncated (floor).
module matvec_seq
  import matvec_pkg::*;
#(
  parameter int N     = 16,
  parameter int FRAC  = N - 2,
  parameter int QB    = 2,
  parameter int LANES = 1
) (
  input logic         clk,
  input logic         rst_n,
  matvec_seq_if.slave bus
);

  localparam int D      = vec_dim(QB);
  localparam int ACC_W  = acc_width(N, QB);
  localparam int GROUPS = D / LANES;
  localparam int RG_W   = (GROUPS > 1) ? $clog2(GROUPS) : 1;

  localparam logic [1:0] IDLE = ST_IDLE;
  localparam logic [1:0] RUN  = ST_RUN;
  localparam logic [1:0] DONE = ST_DONE;

  if (LANES < 1 || (LANES & (LANES - 1)) != 0 || (D % LANES) != 0) begin : g_bad_lanes
    $error("matvec_seq: LANES=%0d must be a power of two dividing D=%0d", LANES, D);
  end
  if (QB < 1 || FRAC < 1 || FRAC >= N || N >= CPLX_W || ACC_W + 1 > WIDE_W) begin : g_bad_width
    $error("matvec_seq: unsupported N=%0d FRAC=%0d QB=%0d", N, FRAC, QB);
  end

  logic [1:0]      state;
  logic [QB-1:0]   col;
  logic [RG_W-1:0] row_grp;
  logic            ovr_q;
  logic [N-1:0]    m_q [0:2*D*D-1];
  logic [N-1:0]    v_q [0:2*D-1];
  logic [N-1:0]    o_q [0:2*D-1];

  logic            accept, running, last_col, last_grp;
  logic            lane_clr, any_ovf;
  cplx_t           v_op;
  logic [QB-1:0]   lane_row [LANES];
  logic signed [ACC_W-1:0] sum_re [LANES];
  logic signed [ACC_W-1:0] sum_im [LANES];
  sat_t            res_re [LANES];
  sat_t            res_im [LANES];

  assign accept   = (state == IDLE) && bus.start;
  assign running  = (state == RUN);
  assign last_col = (col == QB'(D - 1));
  assign last_grp = (row_grp == RG_W'(GROUPS - 1));
  // The accept clear is redundant after a clean run but keeps each run
  // independent of whatever the lanes held before.
  assign lane_clr = accept || (running && last_col);

  // NOTE: every variable written in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    any_ovf = 1'b0;
    v_op.re = CPLX_W'(signed'(v_q[{col, 1'b0}]));
    v_op.im = CPLX_W'(signed'(v_q[{col, 1'b1}]));
    for (int l = 0; l < LANES; l++) begin
      lane_row[l] = QB'(int'(row_grp) * LANES + l);
      res_re[l]   = sat_round(WIDE_W'(sum_re[l]), N, FRAC);
      res_im[l]   = sat_round(WIDE_W'(sum_im[l]), N, FRAC);
      any_ovf     = any_ovf | res_re[l].ovf | res_im[l].ovf;
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    cplx_t m_op;
    logic  unused_hi;

    // Row-major element (row, col) sits at word 2*(row*D + col).
    always_comb begin
      m_op.re = CPLX_W'(signed'(m_q[{lane_row[l], col, 1'b0}]));
      m_op.im = CPLX_W'(signed'(m_q[{lane_row[l], col, 1'b1}]));
    end

    // Saturated results always fit in N bits.
    assign unused_hi = ^{res_re[l].val[CPLX_W-1:N], res_im[l].val[CPLX_W-1:N]};

    cmac_lane #(.N(N), .QB(QB)) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (lane_clr),
      .en     (running),
      .m      (m_op),
      .v      (v_op),
      .sum_re (sum_re[l]),
      .sum_im (sum_im[l])
    );
  end

  // NOTE: the operand copies are plain storage, only ever read after an
  // accepting edge loads them, so they take no reset (cheaper, no fanout on
  // rst_n); control state and outputs are reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      m_q <= bus.matrix;
      v_q <= bus.i_vector;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      col     <= '0;
      row_grp <= '0;
      ovr_q   <= 1'b0;
      for (int i = 0; i < 2 * D; i++) o_q[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state   <= RUN;
            col     <= '0;
            row_grp <= '0;
            ovr_q   <= 1'b0;
          end
        end
        RUN: begin
          if (last_col) begin
            col <= '0;
            for (int l = 0; l < LANES; l++) begin
              o_q[{lane_row[l], 1'b0}] <= res_re[l].val[N-1:0];
              o_q[{lane_row[l], 1'b1}] <= res_im[l].val[N-1:0];
            end
            ovr_q <= ovr_q | any_ovf;
            if (last_grp) begin
              state   <= DONE;
              row_grp <= '0;
            end else begin
              row_grp <= row_grp + 1'b1;
            end
          end else begin
            col <= col + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy     = (state != IDLE);
  assign bus.done     = (state == DONE);
  assign bus.o_vector = o_q;
  assign bus.ovr      = ovr_q;

endmodule
